// File: rtl/kuuga_data_mem_responder.sv
// rtl/kuuga_data_mem_responder.sv - RI5CY-protocol data-memory responder with grant/latency timing and statistics
module kuuga_data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GNT_DELAY  = 0,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic [31:0]             gnt_count,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
);

    localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH     = 2 ** IDX_W;
    localparam int          BE_W      = int'(DATA_WIDTH / 8);
    // LAT holds for LATENCY-1 cycles, counting down to zero inclusive.
    localparam logic [31:0] LCNT_INIT = (LATENCY > 1) ? 32'(LATENCY - 2) : 32'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LAT  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              gcnt_q, gcnt_d;
    logic [31:0]             lcnt_q, lcnt_d;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [31:0]             gnt_cnt_q, rd_cnt_q, wr_cnt_q;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [IDX_W-1:0]        idx;
    logic                    grant;
    logic                    unused_addr_bits;

    assign idx              = data_addr_i[ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^data_addr_i[1:0];

    // Grant only from IDLE once the request has been held GNT_DELAY cycles; never in reset.
    always_comb begin
        grant = rst_n && (state_q == S_IDLE) && data_req_i && (gcnt_q == 4'(GNT_DELAY));
    end

    // Next-state, grant-delay and latency counters.
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    gcnt_d = 4'd0;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAT;
                        lcnt_d  = LCNT_INIT;
                    end
                end else if (data_req_i && (gcnt_q != 4'(GNT_DELAY))) begin
                    gcnt_d = gcnt_q + 4'd1;
                end else begin
                    gcnt_d = 4'd0;
                end
            end
            S_LAT: begin
                if (lcnt_q == 32'd0) begin
                    state_d = S_RESP;
                end else begin
                    lcnt_d = lcnt_q - 32'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gcnt_d  = 4'd0;
                lcnt_d  = 32'd0;
            end
        endcase
    end

    // State, response capture and statistics registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gcnt_q    <= 4'd0;
            lcnt_q    <= 32'd0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            gnt_cnt_q <= 32'd0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            lcnt_q  <= lcnt_d;
            if (grant) begin
                we_q      <= data_we_i;
                gnt_cnt_q <= gnt_cnt_q + 32'd1;
                if (data_we_i) begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 32'd1;
                    rdata_q  <= mem[idx];
                end
            end
        end
    end

    // Byte-lane writes commit on the grant edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (grant && data_we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Response outputs: data only on a read response, zero otherwise.
    always_comb begin
        data_gnt_o    = grant;
        data_rvalid_o = (state_q == S_RESP);
        data_rdata_o  = ((state_q == S_RESP) && !we_q) ? rdata_q : '0;
        gnt_count     = gnt_cnt_q;
        read_count    = rd_cnt_q;
        write_count   = wr_cnt_q;
    end

endmodule

// File: tb/tb_kuuga_data_mem_responder.sv
// tb/tb_kuuga_data_mem_responder.sv - scoreboard bench for two timing configurations of the responder
module tb_kuuga_data_mem_responder;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic        we [2];
    logic [15:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic        gnt [2];
    logic        rv [2];
    logic [31:0] rd [2];
    logic [31:0] gc [2];
    logic [31:0] rc [2];
    logic [31:0] wc [2];

    int          gd_cfg [2] = '{0, 3};
    int          lt_cfg [2] = '{1, 4};

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mm [2][8];
    int unsigned mg [2];
    int unsigned mr [2];
    int unsigned mw [2];
    bit          outstanding [2];
    int          gcyc [2];
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    kuuga_data_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GNT_DELAY(0), .LATENCY(1)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_wdata_i(wd[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rv[0]), .data_rdata_o(rd[0]),
        .gnt_count(gc[0]), .read_count(rc[0]), .write_count(wc[0])
    );

    kuuga_data_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GNT_DELAY(3), .LATENCY(4)) u_slow (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_wdata_i(wd[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rv[1]), .data_rdata_o(rd[1]),
        .gnt_count(gc[1]), .read_count(rc[1]), .write_count(wc[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_exp(input int k, output exp_t e);
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    // Monitor: one response per grant, at the configured latency, in order.
    task automatic mon(input int k);
        exp_t e;
        if (rv[k]) begin
            chk("rvalid_expected", k, 32'(qsize(k) != 0), 32'd1);
            if (qsize(k) != 0) begin
                pop_exp(k, e);
                chk("rdata", k, rd[k], e.rd ? e.data : 32'd0);
                chk("rvalid_latency", k, 32'(cyc - gcyc[k]), 32'(lt_cfg[k]));
            end
            outstanding[k] = 1'b0;
        end else begin
            chk("rdata_idle", k, rd[k], 32'd0);
        end
        if (gnt[k]) begin
            chk("gnt_while_outstanding", k, 32'(outstanding[k]), 32'd0);
            outstanding[k] = 1'b1;
            gcyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the grant edge.
    task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [3:0] b,
                         input logic [31:0] d, input bit chk_gd);
        int   waited = 0;
        bit   got = 1'b0;
        int   wi;
        exp_t e;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wd[k] = d;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (gnt[k]) got = 1'b1;
            else        waited++;
        end
        chk("gnt_seen", k, 32'(got), 32'd1);
        if (got) begin
            if (chk_gd) chk("gnt_delay", k, 32'(waited), 32'(gd_cfg[k]));
            wi = int'(a[4:2]);
            mg[k]++;
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mm[k][wi][8*i +: 8] = d[8*i +: 8];
                mw[k]++;
                e.rd = 1'b0; e.data = 32'd0;
            end else begin
                mr[k]++;
                e.rd = 1'b1; e.data = mm[k][wi];
            end
            push_exp(k, e);
        end
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        we[k] = 1'($urandom); addr[k] = 16'($urandom); be[k] = 4'($urandom); wd[k] = $urandom;
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (qsize(k) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", k, 32'(qsize(k)), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input int k);
        chk("gnt_count", k, gc[k], mg[k]);
        chk("read_count", k, rc[k], mr[k]);
        chk("write_count", k, wc[k], mw[k]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            outstanding[k] = 1'b0;
            mg[k] = 0; mr[k] = 0; mw[k] = 0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_op(input int k, input bit rd_op);
        logic [15:0] a;
        a = 16'({$urandom_range(0, 7), 2'($urandom)});
        issue(k, !rd_op, a, 4'($urandom), $urandom, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int rl;
        int wl;
        bit r;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wd[k] = '0;
            outstanding[k] = 1'b0; gcyc[k] = 0;
            mg[k] = 0; mr[k] = 0; mw[k] = 0;
        end
        // Request held during reset must not be granted.
        req[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("gnt_in_reset", 0, 32'(gnt[0]), 32'd0);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 2; k++) begin
            chk("reset_gnt", k, 32'(gnt[k]), 32'd0);
            chk("reset_rvalid", k, 32'(rv[k]), 32'd0);
            chk("reset_rdata", k, rd[k], 32'd0);
            check_counts(k);
        end
        mon_en = 1'b1;

        for (int k = 0; k < 2; k++) begin
            // Known contents for the exercised words.
            for (int i = 0; i < 8; i++) begin
                issue(k, 1'b1, 16'(i * 4), 4'hF, $urandom, 1'b1);
                drain(k);
            end
            // Full-word write then read back.
            issue(k, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b1);
            drain(k);
            issue(k, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1);
            drain(k);
            // Partial lanes; low address bits ignored on the read.
            issue(k, 1'b1, 16'h0010, 4'b0101, 32'h11223344, 1'b1);
            drain(k);
            issue(k, 1'b0, 16'h0012, 4'hF, 32'hFFFFFFFF, 1'b1);
            drain(k);
            check_counts(k);
        end

        // Abandoned request: no grant, and the next request waits the full delay.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0004; be[1] = 4'hF; wd[1] = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("gnt_abandoned", 1, 32'(gnt[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        req[1] = 1'b0;
        idle(1);
        check_counts(1);
        issue(1, 1'b0, 16'h0004, 4'h0, 32'h0, 1'b1);
        drain(1);
        check_counts(1);

        // Random traffic with random gaps on both instances.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 20; i++) begin
                rand_op(k, 1'($urandom));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
            drain(k);
            check_counts(k);
        end

        // Reset while a read sits in LAT: response lost, counters cleared, memory kept.
        issue(1, 1'b0, 16'h0008, 4'h0, 32'h0, 1'b0);
        do_reset();
        idle(8);
        check_counts(0);
        check_counts(1);
        issue(1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1);
        drain(1);
        issue(0, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1);
        drain(0);

        // Ten back-to-back requests, six reads and four writes, after a fresh reset.
        do_reset();
        idle(2);
        for (int k = 0; k < 2; k++) begin
            rl = 6;
            wl = 4;
            for (int i = 0; i < 10; i++) begin
                r = ($urandom_range(0, rl + wl - 1) < rl);
                if (r) rl--; else wl--;
                rand_op(k, r);
            end
            drain(k);
            chk("b2b_gnt_count", k, gc[k], 32'd10);
            chk("b2b_read_count", k, rc[k], 32'd6);
            chk("b2b_write_count", k, wc[k], 32'd4);
            check_counts(k);
        end

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
